mips_dmem_responder: RTL and testbench



---
 rtl/mips_mem_pkg.sv | 22 ++
 rtl/mips_dmem_if.sv | 31 +++
 rtl/mips_dmem_array.sv | 49 ++++
 rtl/mips_dmem_responder.sv | 118 +++++++++++
 tb/tb_mips_dmem_responder.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and constants for the MIPS data-memory responder
//
// Provides the word/byte-enable widths, the responder FSM state type and the
// legal latency range. Imported by the interface, the array and the responder.

package mips_mem_pkg;

    localparam int WORD_W  = 32;
    localparam int BE_W    = WORD_W / 8;

    // Legal programmable latency range and the counter width that covers it.
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 8;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mips_dmem_if.sv
// rtl/mips_dmem_if.sv - load/store request and response bundle between MEM stage and data memory
//
// Request:  req_valid, req_ready, req_we, req_addr (byte), req_wdata, req_be
// Response: rsp_valid, rsp_ready, rsp_rdata, rsp_err
// master = core side, slave = memory responder side.

interface mips_dmem_if;
    import mips_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mips_dmem_array.sv
// rtl/mips_dmem_array.sv - single-port byte-enabled word array with synchronous read
//
// Ports:
//   clk    in   clock
//   en     in   access enable for this cycle
//   we     in   1 = write enabled bytes, 0 = read word into rdata
//   be     in   per-byte write enables
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  read data, updated only on enabled reads and held otherwise
// Contents and the read register are deliberately not reset.

module mips_dmem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 8192,
    parameter int AW          = 13
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    // The read register doubles as the responder's load hold register: it only
    // changes on an enabled read, so it stays stable through WAIT and RESP.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mips_dmem_responder.sv
// rtl/mips_dmem_responder.sv - latency-programmable slave for the MIPS core's load/store path
//
// Ports:
//   clk    in   clock
//   rst_n  in   synchronous active-low reset
//   bus    slave modport of mips_dmem_if (request/response handshakes)
// One request outstanding at a time. Stores commit and loads sample the array
// at the accept edge; the response appears LATENCY cycles later and is held
// until rsp_ready.

module mips_dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 8192,
    parameter int LATENCY     = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    mips_dmem_if.slave   bus
);

    localparam int AW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // Out-of-range latencies are clamped rather than producing a broken counter.
    localparam int LAT = (LATENCY < LAT_MIN) ? LAT_MIN :
                         (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_load_q, rsp_load_d;

    logic              accept;
    logic              addr_err;
    logic [WORD_W-1:0] arr_rdata;

    // req_ready_q is only high in IDLE, so it alone qualifies acceptance.
    assign accept   = bus.req_valid & req_ready_q;
    assign addr_err = (bus.req_addr[1:0] != 2'b00) ||
                      ({2'b00, bus.req_addr[WORD_W-1:2]} >= 32'(DEPTH_WORDS));

    mips_dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .en    (accept & ~addr_err),
        .we    (bus.req_we),
        .be    (bus.req_be),
        .addr  (bus.req_addr[AW+1:2]),
        .wdata (bus.req_wdata),
        .rdata (arr_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rsp_err_d  = rsp_err_q;
        rsp_load_d = rsp_load_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    rsp_err_d  = addr_err;
                    rsp_load_d = ~bus.req_we & ~addr_err;
                    cnt_d      = CNT_W'(LAT - 1);
                    state_d    = (LAT > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d    = IDLE;
                    rsp_err_d  = 1'b0;
                    rsp_load_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_load_q  <= rsp_load_d;
        end
    end

    // Error and load-data flags are captured at accept; gating with rsp_valid
    // keeps both outputs at zero outside the response window.
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_valid_q & rsp_err_q;
    assign bus.rsp_rdata = (rsp_valid_q & rsp_load_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// tb/tb_mips_dmem_responder.sv - randomized self-checking bench for mips_dmem_responder

module tb_mips_dmem_responder;

    localparam int DEPTH   = 8192;
    localparam int LAT     = 2;
    localparam int DEPTH1  = 64;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [31:0] mdl  [int];
    logic [31:0] mdl1 [int];

    mips_dmem_if m_if ();
    mips_dmem_if l1_if ();

    mips_dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if)
    );

    mips_dmem_responder #(.DEPTH_WORDS(DEPTH1), .LATENCY(1)) u_dut_l1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (l1_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic addr_bad(input logic [31:0] a, input int depth);
        return (a % 4 != 0) || ((a / 4) >= 32'(depth));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] w;
        w = old;
        for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
        return w;
    endfunction

    // Applies a request to the behavioural memory; returns the expected response.
    task automatic model_apply(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, output logic [31:0] exp_d, output logic exp_e);
        int w;
        exp_e = addr_bad(addr, DEPTH);
        exp_d = 32'h0;
        w = int'(addr / 4);
        if (!exp_e) begin
            if (we) mdl[w] = merge(mdl.exists(w) ? mdl[w] : 32'h0, wdata, be);
            else    exp_d = mdl.exists(w) ? mdl[w] : 32'h0;
        end
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold);
        int          k;
        logic [31:0] exp_d;
        logic        exp_e;
        k = 0;
        while (!m_if.req_ready && k < 20) begin @(negedge clk); k++; end
        check("req_ready_idle", m_if.req_ready, 1);
        model_apply(we, addr, wdata, be, exp_d, exp_e);
        m_if.req_valid = 1; m_if.req_we = we; m_if.req_addr = addr;
        m_if.req_wdata = wdata; m_if.req_be = be; m_if.rsp_ready = 0;
        @(posedge clk);
        @(negedge clk);
        m_if.req_valid = 0;
        k = 1;
        while (!m_if.rsp_valid && k < 20) begin @(negedge clk); k++; end
        check("latency", k, LAT);
        check("rsp_rdata", m_if.rsp_rdata, exp_d);
        check("rsp_err", m_if.rsp_err, exp_e);
        for (int i = 0; i < hold; i++) begin
            // A competing store that must not be captured while busy.
            m_if.req_valid = 1; m_if.req_we = 1; m_if.req_addr = 32'h10;
            m_if.req_wdata = 32'h12345678; m_if.req_be = 4'hF;
            @(negedge clk);
            check("hold_valid", m_if.rsp_valid, 1);
            check("hold_rdata", m_if.rsp_rdata, exp_d);
            check("hold_err", m_if.rsp_err, exp_e);
            check("hold_ready", m_if.req_ready, 0);
        end
        m_if.req_valid = 0;
        m_if.rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        m_if.rsp_ready = 0;
        check("post_rsp_valid", m_if.rsp_valid, 0);
        check("post_req_ready", m_if.req_ready, 1);
    endtask

    task automatic reset_during_wait(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] exp_d;
        logic        exp_e;
        check("rst_wait_ready", m_if.req_ready, 1);
        model_apply(we, addr, wdata, 4'hF, exp_d, exp_e);
        m_if.req_valid = 1; m_if.req_we = we; m_if.req_addr = addr;
        m_if.req_wdata = wdata; m_if.req_be = 4'hF; m_if.rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        m_if.req_valid = 0;
        check("rst_wait_novalid", m_if.rsp_valid, 0);
        rst_n = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        check("rst_ready_low", m_if.req_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check("rst_ready_back", m_if.req_ready, 1);
        for (int i = 0; i < 4; i++) begin
            check("rst_dropped", m_if.rsp_valid, 0);
            @(negedge clk);
        end
        m_if.rsp_ready = 0;
    endtask

    task automatic run_l1;
        logic [31:0] op_addr [16];
        logic [31:0] op_data [16];
        logic        op_we   [16];
        logic [32:0] exp_q [$];
        logic [32:0] e;
        int cyc, last_acc, idx, accepts;
        for (int i = 0; i < 8; i++) begin
            op_we[i] = 1; op_addr[i] = 32'(4*i); op_data[i] = $urandom;
            op_we[8+i] = 0; op_addr[8+i] = 32'(4*i); op_data[8+i] = 32'h0;
        end
        op_addr[15] = 32'(4*DEPTH1);
        cyc = 0; last_acc = -100; idx = 0; accepts = 0;
        l1_if.rsp_ready = 1;
        while (cyc < 100 && (idx < 16 || exp_q.size() != 0)) begin
            @(negedge clk);
            cyc++;
            if (l1_if.rsp_valid) begin
                check("l1_rsp_lat", cyc - last_acc, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("l1_rdata", l1_if.rsp_rdata, e[31:0]);
                    check("l1_err", l1_if.rsp_err, e[32]);
                end else begin
                    check("l1_spurious_rsp", 1, 0);
                end
            end
            if (idx < 16) begin
                l1_if.req_valid = 1; l1_if.req_we = op_we[idx];
                l1_if.req_addr = op_addr[idx]; l1_if.req_wdata = op_data[idx];
                l1_if.req_be = 4'hF;
                if (l1_if.req_ready) begin
                    if (last_acc >= 0) check("l1_spacing", cyc - last_acc, 2);
                    last_acc = cyc;
                    accepts++;
                    if (addr_bad(op_addr[idx], DEPTH1)) e = {1'b1, 32'h0};
                    else if (op_we[idx]) begin
                        mdl1[int'(op_addr[idx] / 4)] = op_data[idx];
                        e = {1'b0, 32'h0};
                    end else e = {1'b0, mdl1[int'(op_addr[idx] / 4)]};
                    exp_q.push_back(e);
                    idx++;
                end
            end else begin
                l1_if.req_valid = 0;
            end
        end
        check("l1_accepts", accepts, 16);
    endtask

    initial begin
        logic        we;
        logic [31:0] addr;
        int          sel;
        checks = 0; failures = 0;
        m_if.req_valid = 0; m_if.req_we = 0; m_if.req_addr = 0;
        m_if.req_wdata = 0; m_if.req_be = 0; m_if.rsp_ready = 0;
        l1_if.req_valid = 0; l1_if.req_we = 0; l1_if.req_addr = 0;
        l1_if.req_wdata = 0; l1_if.req_be = 0; l1_if.rsp_ready = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        check("reset_req_ready", m_if.req_ready, 0);
        check("reset_rsp_valid", m_if.rsp_valid, 0);
        check("reset_rsp_rdata", m_if.rsp_rdata, 0);
        check("reset_rsp_err", m_if.rsp_err, 0);
        rst_n = 1;
        @(negedge clk);
        check("first_ready", m_if.req_ready, 1);

        do_req(1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        do_req(0, 32'h10, 32'h0, 4'h0, 0);
        do_req(1, 32'h10, 32'h000000AA, 4'b0001, 0);
        do_req(0, 32'h10, 32'h0, 4'hF, 0);
        check("byte_merge", mdl[4], 32'hDEADBEAA);
        do_req(0, 32'h12, 32'h0, 4'hF, 0);
        do_req(0, 32'(4*DEPTH), 32'h0, 4'hF, 0);
        do_req(1, 32'(4*DEPTH), 32'hFFFFFFFF, 4'hF, 0);
        do_req(1, 32'h10, 32'h55555555, 4'h0, 0);
        do_req(0, 32'h10, 32'h0, 4'hF, 0);
        do_req(0, 32'h10, 32'h0, 4'hF, 5);
        do_req(0, 32'h10, 32'h0, 4'hF, 0);

        reset_during_wait(0, 32'h10, 32'h0);
        reset_during_wait(1, 32'h20, 32'hCAFEF00D);
        do_req(0, 32'h20, 32'h0, 4'hF, 0);

        for (int w = 0; w < 16; w++) do_req(1, 32'(4*w), $urandom, 4'hF, 0);
        for (int n = 0; n < 60; n++) begin
            we  = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       addr = 32'(4 * $urandom_range(0, 15));
            else if (sel == 7) addr = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
            else if (sel == 8) addr = 32'(4 * DEPTH + 4 * $urandom_range(0, 100));
            else               addr = {1'b1, 31'($urandom)} & 32'hFFFF_FFFC;
            do_req(we, addr, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
        end

        run_l1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
